// File: rtl/muldiv_unit_pkg.sv
// Shared core package: ALU operation codes plus the types and constants used by
// the RV32M multiply/divide unit.
package muldiv_unit_pkg;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
   } alu_t;

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} muldiv_state_t;

   localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN       = 32'h8000_0000;

   function automatic logic is_muldiv_op(alu_t op);
      return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift remainder:dividend left by one,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic [XLEN-1:0] dvd_in,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic [XLEN-1:0] dvd_out,
   output logic            q_bit
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] trial;

   // The remainder is always below the divisor, so XLEN+1 bits hold the shift;
   // the top bit of the trial difference is its sign.
   always_comb begin
      shifted = {rem_in, dvd_in[XLEN-1]};
      trial   = shifted - {1'b0, divisor};
      q_bit   = ~trial[XLEN];
      rem_out = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
      dvd_out = {dvd_in[XLEN-2:0], 1'b0};
   end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide execute unit: 2-cycle multiply, 32-iteration restoring
// divide, valid/ready on both sides and a synchronous flush.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned DIV_ITERS = XLEN
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  alu_t            alu_ctrl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   muldiv_state_t   state_q, state_d;
   alu_t            op_q, op_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d;
   logic [XLEN-1:0] rem_q, rem_d, dvd_q, dvd_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [4:0]      cnt_q, cnt_d;
   logic            neg_q, neg_d, rem_sel_q, rem_sel_d;

   logic            is_mul, is_div, is_rem, signed_div, div0, ovf;
   logic [XLEN-1:0] abs_a, abs_b, special, fix_val;
   logic [63:0]     ma, mb, prod;
   logic [XLEN-1:0] mul_res;
   logic [XLEN-1:0] step_rem, step_dvd;
   logic            step_q;

   div_step #(.XLEN(XLEN)) u_step (
      .rem_in (rem_q),
      .dvd_in (dvd_q),
      .divisor(b_q),
      .rem_out(step_rem),
      .dvd_out(step_dvd),
      .q_bit  (step_q)
   );

   always_comb begin
      is_mul     = alu_ctrl inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
      is_div     = is_muldiv_op(alu_ctrl) && !is_mul;
      is_rem     = alu_ctrl inside {ALU_REM, ALU_REMU};
      signed_div = alu_ctrl inside {ALU_DIV, ALU_REM};
      div0       = (op_b == '0);
      ovf        = signed_div && (op_a == INT_MIN) && (op_b == '1);
      abs_a      = (signed_div && op_a[XLEN-1]) ? -op_a : op_a;
      abs_b      = (signed_div && op_b[XLEN-1]) ? -op_b : op_b;
      if (div0) special = is_rem ? op_a : DIV0_QUOTIENT;
      else      special = is_rem ? '0   : INT_MIN;

      ma      = {{32{(op_q inside {ALU_MULH, ALU_MULHSU}) && a_q[XLEN-1]}}, a_q};
      mb      = {{32{(op_q == ALU_MULH) && b_q[XLEN-1]}}, b_q};
      prod    = ma * mb;
      mul_res = (op_q == ALU_MUL) ? prod[31:0] : prod[63:32];
      fix_val = rem_sel_q ? rem_q : dvd_q;
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      result_d  = result_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      rem_sel_d = rem_sel_q;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: if (req_valid) begin
               op_d      = alu_ctrl;
               a_d       = op_a;
               cnt_d     = '0;
               neg_d     = 1'b0;
               rem_sel_d = is_rem;
               if (is_mul) begin
                  b_d     = op_b;
                  state_d = MUL;
               end else if (is_div && (div0 || ovf)) begin
                  // Special results ride through FIX unmodified so they share
                  // the multiply's two-edge latency without touching DIV.
                  rem_d     = special;
                  rem_sel_d = 1'b1;
                  state_d   = FIX;
               end else if (is_div) begin
                  b_d     = abs_b;
                  dvd_d   = abs_a;
                  rem_d   = '0;
                  neg_d   = (alu_ctrl == ALU_DIV) ? (op_a[XLEN-1] ^ op_b[XLEN-1])
                                                  : ((alu_ctrl == ALU_REM) && op_a[XLEN-1]);
                  state_d = DIV;
               end else begin
                  result_d = '0;
                  state_d  = DONE;
               end
            end
            MUL: begin
               result_d = mul_res;
               state_d  = DONE;
            end
            DIV: begin
               rem_d = step_rem;
               dvd_d = step_dvd | XLEN'(step_q);
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'(DIV_ITERS - 1)) state_d = FIX;
            end
            FIX: begin
               result_d = neg_q ? -fix_val : fix_val;
               state_d  = DONE;
            end
            DONE: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         op_q      <= ALU_ADD;
         a_q       <= '0;
         b_q       <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         result_q  <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         rem_sel_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         rem_q     <= rem_d;
         dvd_q     <= dvd_d;
         result_q  <= result_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         rem_sel_q <= rem_sel_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table of operations with
// hand-computed results and latencies, plus backpressure, flush and reset runs.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   alu_t        alu_ctrl = ALU_ADD;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] result;
   logic        busy;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // Latency counts edges with the acceptance edge as edge 1.
   typedef struct {
      alu_t        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int unsigned lat;
   } vec_t;

   vec_t vecs[$];

   muldiv_unit #(.XLEN(32), .DIV_ITERS(32)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (flush),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .alu_ctrl (alu_ctrl),
      .op_a     (op_a),
      .op_b     (op_b),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .result   (result),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic issue(input alu_t op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      check("req_ready_before_issue", {31'b0, req_ready}, 32'd1);
      alu_ctrl  = op;
      op_a      = a;
      op_b      = b;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int unsigned edges, output logic busy_ok);
      edges   = 1;
      busy_ok = 1'b1;
      while (!rsp_valid && edges < 60) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int unsigned edges;
      logic        bok;
      issue(v.op, v.a, v.b);
      wait_rsp(edges, bok);
      check({tag, "_result"}, result, v.exp);
      check({tag, "_latency"}, edges, v.lat);
      check({tag, "_busy"}, {31'b0, bok}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int unsigned edges;
      logic        ok;
      vec_t        v;

      vecs.push_back('{ALU_MUL,    32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 2});
      vecs.push_back('{ALU_MULH,   32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 2});
      vecs.push_back('{ALU_MULHU,  32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 2});
      vecs.push_back('{ALU_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 2});
      vecs.push_back('{ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34});
      vecs.push_back('{ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34});
      vecs.push_back('{ALU_DIVU,   32'd100,       32'd7,         32'd14,        34});
      vecs.push_back('{ALU_REMU,   32'd100,       32'd7,         32'd2,         34});
      vecs.push_back('{ALU_DIV,    32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 34});
      vecs.push_back('{ALU_REM,    32'd20,        32'hFFFF_FFFD, 32'd2,         34});
      vecs.push_back('{ALU_DIV,    32'h8000_0000, 32'd1,         32'h8000_0000, 34});
      vecs.push_back('{ALU_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34});
      vecs.push_back('{ALU_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 2});
      vecs.push_back('{ALU_REM,    32'd5,         32'd0,         32'd5,         2});
      vecs.push_back('{ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2});
      vecs.push_back('{ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2});
      vecs.push_back('{ALU_ADD,    32'd3,         32'd4,         32'd0,         1});

      // Reset state
      #12;
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_busy",      {31'b0, busy},      32'd0);
      check("rst_result",    result,             32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Flush in IDLE must not accept a pending request
      @(negedge clk);
      alu_ctrl  = ALU_MUL;
      op_a      = 32'd9;
      op_b      = 32'd9;
      req_valid = 1'b1;
      flush     = 1'b1;
      @(posedge clk);
      #1;
      check("idle_flush_busy", {31'b0, busy}, 32'd0);
      req_valid = 1'b0;
      flush     = 1'b0;

      // Backpressure: response held stable while rsp_ready is low
      rsp_ready = 1'b0;
      issue(ALU_MUL, 32'd3, 32'd4);
      wait_rsp(edges, ok);
      check("bp_latency", edges, 32'd2);
      ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         if (!rsp_valid || result !== 32'd12 || req_ready || !busy) ok = 1'b0;
      end
      check("bp_hold", {31'b0, ok}, 32'd1);
      check("bp_result", result, 32'd12);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_idle", {30'b0, req_ready, rsp_valid}, 32'd2);
      v = '{ALU_MUL, 32'd5, 32'd5, 32'd25, 2};
      run_vec(v, "bp_next");

      // Flush mid-divide
      issue(ALU_DIVU, 32'd1000, 32'd3);
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_idle", {29'b0, req_ready, rsp_valid, busy}, 32'd4);
      ok = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (rsp_valid || busy) ok = 1'b0;
      end
      check("flush_no_rsp", {31'b0, ok}, 32'd1);
      v = '{ALU_DIVU, 32'd9, 32'd3, 32'd3, 34};
      run_vec(v, "post_flush");

      // Asynchronous reset mid-divide
      issue(ALU_DIVU, 32'd1000, 32'd3);
      repeat (5) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("arst_busy",      {31'b0, busy},      32'd0);
      check("arst_result",    result,             32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      v = '{ALU_MUL, 32'd7, 32'd6, 32'd42, 2};
      run_vec(v, "post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
